// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM encodings and the cycles-per-add helper.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Guarded against DIGIT<1 so the configuration check, not a divide-by-zero, reports the problem.
    function automatic int steps_f(input int width, input int digit);
        return (digit > 0) ? (width / digit) : 1;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// DIGIT-bit ripple adder: a chain of full adders, each built from two half_adder cells and an OR.
module adder_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] c;

    assign c[0] = ci;
    assign co   = c[DIGIT];

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        logic p, g0, g1;

        half_adder u_ha0 (.a(x[i]), .b(y[i]), .sum(p),    .carry(g0));
        half_adder u_ha1 (.a(p),    .b(c[i]), .sum(s[i]), .carry(g1));

        assign c[i+1] = g0 | g1;
    end

endmodule

// File: rtl/half_adder.sv
// Combinational half-adder cell: one-bit sum and carry of two inputs.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder, DIGIT bits per clock with a registered carry and valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int STEPS = steps_f(WIDTH, DIGIT);
    localparam int CW    = $clog2(STEPS + 1);

    if (DIGIT < 1) begin : g_bad_digit
        $error("serial_adder: DIGIT must be >= 1");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
        $error("serial_adder: WIDTH must be a multiple of DIGIT");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    count;

    logic [DIGIT-1:0] slice_s;
    logic             slice_co;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .x  (acc[DIGIT-1:0]),
        .y  (b_sh[DIGIT-1:0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // acc starts as operand A and doubles as the result register: each slice sum enters
    // at the MSB end as the consumed A digit leaves the LSB end.
    if (DIGIT == WIDTH) begin : g_one_step
        assign acc_next = slice_s;
    end else begin : g_multi_step
        assign acc_next = {slice_s, acc[WIDTH-1:DIGIT]};
    end

    assign last      = (count == CW'(STEPS - 1));
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc   <= a;
                        b_sh  <= b;
                        carry <= cin;
                        count <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= slice_co;
                    count <= count + CW'(1);
                    if (last) begin
                        sum   <= acc_next;
                        cout  <= slice_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry into the top bit is recovered from that bit's own operands and sum.
                        ovf   <= acc[DIGIT-1] ^ b_sh[DIGIT-1] ^ slice_s[DIGIT-1] ^ slice_co;
`endif
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three configurations (1/1, 8/1, 8/4) driven from one vector table.
module tb_serial_adder;

    typedef struct {
        int         k;
        string      nm;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        int         lat;
        logic [7:0] s;
        logic       co;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] iv, ir, ov, orr, ci, co;
    logic [7:0] a_s [3];
    logic [7:0] b_s [3];
    logic [0:0] s0;
    logic [7:0] s1, s2;
`ifdef SERIAL_ADDER_OVF_EN
    logic [2:0] ovf_s;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(1), .DIGIT(1)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s[0][0:0]), .b(b_s[0][0:0]), .cin(ci[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .sum(s0),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_s[0]),
`endif
        .cout(co[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s[1]), .b(b_s[1]), .cin(ci[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .sum(s1),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_s[1]),
`endif
        .cout(co[1])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_s[2]), .b(b_s[2]), .cin(ci[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .sum(s2),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_s[2]),
`endif
        .cout(co[2])
    );

    function automatic logic [7:0] sum_of(input int k);
        case (k)
            0:       return {7'b0, s0};
            1:       return s1;
            default: return s2;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        chk({v.nm, " in_ready before"}, 32'(ir[v.k]), 32'd1);
        iv[v.k] = 1'b1; a_s[v.k] = v.a; b_s[v.k] = v.b; ci[v.k] = v.c; orr[v.k] = 1'b1;
        @(posedge clk); #1;
        iv[v.k] = 1'b0;
        n = 0;
        while (!ov[v.k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({v.nm, " latency"}, 32'(n), 32'(v.lat));
        chk({v.nm, " sum"}, 32'(sum_of(v.k)), 32'(v.s));
        chk({v.nm, " cout"}, 32'(co[v.k]), 32'(v.co));
`ifdef SERIAL_ADDER_OVF_EN
        chk({v.nm, " ovf"}, 32'(ovf_s[v.k]), 32'(v.ovf));
`endif
        @(posedge clk); #1;
        chk({v.nm, " back to idle"}, 32'({ov[v.k], ir[v.k]}), 32'b01);
    endtask

    vec_t tbl [11];

    initial begin
        int acc_at [8];
        int nacc;
        int n;
        int stale;

        tbl[0]  = '{0, "w1 0+0",       8'h00, 8'h00, 1'b0, 1, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{0, "w1 0+1",       8'h00, 8'h01, 1'b0, 1, 8'h01, 1'b0, 1'b0};
        tbl[2]  = '{0, "w1 1+0",       8'h01, 8'h00, 1'b0, 1, 8'h01, 1'b0, 1'b0};
        tbl[3]  = '{0, "w1 1+1",       8'h01, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b1};
        tbl[4]  = '{1, "w8d1 0F+01",   8'h0F, 8'h01, 1'b0, 8, 8'h10, 1'b0, 1'b0};
        tbl[5]  = '{1, "w8d1 FF+00+1", 8'hFF, 8'h00, 1'b1, 8, 8'h00, 1'b1, 1'b0};
        tbl[6]  = '{1, "w8d1 7F+01",   8'h7F, 8'h01, 1'b0, 8, 8'h80, 1'b0, 1'b1};
        tbl[7]  = '{1, "w8d1 FF+01",   8'hFF, 8'h01, 1'b0, 8, 8'h00, 1'b1, 1'b0};
        tbl[8]  = '{2, "w8d4 A5+5B",   8'hA5, 8'h5B, 1'b0, 2, 8'h00, 1'b1, 1'b0};
        tbl[9]  = '{2, "w8d4 12+34+1", 8'h12, 8'h34, 1'b1, 2, 8'h47, 1'b0, 1'b0};
        tbl[10] = '{2, "w8d4 7F+01",   8'h7F, 8'h01, 1'b0, 2, 8'h80, 1'b0, 1'b1};

        rst_n = 1'b0; iv = '0; orr = '1; ci = '0;
        for (int i = 0; i < 3; i++) begin a_s[i] = '0; b_s[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset handshake %0d", k), 32'({ov[k], ir[k]}), 32'b01);
            chk($sformatf("reset sum %0d", k), 32'(sum_of(k)), 32'd0);
            chk($sformatf("reset cout %0d", k), 32'(co[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(tbl[i]);

        // Back-to-back: in_valid held high, accepts must land every STEPS+2 = 4 cycles.
        @(negedge clk);
        iv[2] = 1'b1; a_s[2] = 8'h11; b_s[2] = 8'h22; ci[2] = 1'b0; orr[2] = 1'b1;
        nacc = 0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            if (ir[2] && nacc < 8) begin acc_at[nacc] = i; nacc++; end
        end
        iv[2] = 1'b0;
        chk("b2b accept count", 32'(nacc), 32'd4);
        chk("b2b spacing 0-1", 32'(acc_at[1] - acc_at[0]), 32'd4);
        chk("b2b spacing 2-3", 32'(acc_at[3] - acc_at[2]), 32'd4);
        n = 0;
        while (!ir[2] && n < 10) begin @(negedge clk); n++; end
        chk("b2b drained", 32'(ir[2]), 32'd1);
        chk("b2b sum", 32'(s2), 32'h33);

        // Backpressure: DONE held for 5 cycles, a new request must be ignored.
        @(negedge clk);
        iv[1] = 1'b1; a_s[1] = 8'h0F; b_s[1] = 8'h01; ci[1] = 1'b0; orr[1] = 1'b0;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        n = 0;
        while (!ov[1] && n < 40) begin @(posedge clk); #1; n++; end
        chk("bp latency", 32'(n), 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv[1] = 1'b1; a_s[1] = 8'hAA; b_s[1] = 8'h55;
            @(posedge clk); #1;
            chk($sformatf("bp hold handshake %0d", i), 32'({ov[1], ir[1]}), 32'b10);
            chk($sformatf("bp hold sum %0d", i), 32'(s1), 32'h10);
            chk($sformatf("bp hold cout %0d", i), 32'(co[1]), 32'd0);
        end
        @(negedge clk);
        orr[1] = 1'b1; iv[1] = 1'b0;
        @(posedge clk); #1;
        chk("bp release handshake", 32'({ov[1], ir[1]}), 32'b01);
        chk("bp sum kept after done", 32'(s1), 32'h10);

        // Reset on the 3rd RUN edge aborts the add and clears the outputs.
        @(negedge clk);
        iv[1] = 1'b1; a_s[1] = 8'h55; b_s[1] = 8'h22;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort handshake", 32'({ov[1], ir[1]}), 32'b01);
        chk("abort sum", 32'(s1), 32'd0);
        chk("abort cout", 32'(co[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov[1]) stale++;
        end
        chk("abort no stale result", 32'(stale), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
